// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller side (master) consumes instruction fields and status and
// drives every mux select, write enable and the debug state code.
interface mips_multicycle_control_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic       PCEn;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUControl;
  logic       ExtOp;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
           PCEn, ALUSrcB, PCSrc, ALUControl, ExtOp, illegal_op, state
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
           PCEn, ALUSrcB, PCSrc, ALUControl, ExtOp, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore main controller for the multicycle MIPS datapath. One state
// register; all controls are decoded combinationally from the state plus
// the instruction fields, Zero (PCEn only) and the memory handshake.
module mips_multicycle_control (
  input  logic clk,
  input  logic rst_n,
  mips_multicycle_control_if.master ctrl
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_reg, state_next;
  logic [2:0] funct_alu, imm_alu;
  logic       funct_ok;
  logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic       pcwrite, branch, extop, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  // R-type function decode and I-type ALU operation selection.
  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (ctrl.Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
    imm_alu = ALU_ADD;
    case (ctrl.Op)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      default: imm_alu = ALU_ADD;
    endcase
  end

  // Next-state and per-state control outputs; everything idles at 0
  // except ExtOp, which defaults to sign-extension.
  always_comb begin
    state_next = S_FETCH;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    extop      = 1'b1;
    illegal    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    case (state_reg)
      S_FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = ctrl.mem_ready;
        pcwrite    = ctrl.mem_ready;
        state_next = ctrl.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (ctrl.Op)
          OP_LW, OP_SW:             state_next = S_MEMADR;
          OP_RTYPE: begin
            state_next = S_EXECUTE;
            illegal    = !funct_ok;
          end
          OP_BEQ:                   state_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_next = S_IEXEC;
          OP_J:                     state_next = S_JUMP;
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        state_next = (ctrl.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = ctrl.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        state_next = ctrl.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_IEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = imm_alu;
        extop      = (ctrl.Op == OP_ADDI);
        state_next = S_IWB;
      end
      S_IWB: begin
        regwrite   = 1'b1;
        alucontrol = imm_alu;
        extop      = (ctrl.Op == OP_ADDI);
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Write enables are gated by reset so none can rise while rst_n is low.
  assign ctrl.IorD       = iord;
  assign ctrl.IRWrite    = irwrite & rst_n;
  assign ctrl.MemWrite   = memwrite & rst_n;
  assign ctrl.RegWrite   = regwrite & rst_n;
  assign ctrl.RegDst     = regdst;
  assign ctrl.MemtoReg   = memtoreg;
  assign ctrl.ALUSrcA    = alusrca;
  assign ctrl.PCEn       = (pcwrite | (branch & ctrl.Zero)) & rst_n;
  assign ctrl.ALUSrcB    = alusrcb;
  assign ctrl.PCSrc      = pcsrc;
  assign ctrl.ALUControl = alucontrol;
  assign ctrl.ExtOp      = extop;
  assign ctrl.illegal_op = illegal & rst_n;
  assign ctrl.state      = state_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for the multicycle MIPS controller: an instruction-level model
// (a queue of remaining steps per instruction plus a per-step control
// profile) is compared against the DUT every cycle, with directed
// scenarios pinned by literal expectations and a randomized run.
module tb_mips_multicycle_control;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  mips_multicycle_control_if bus();

  mips_multicycle_control dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_cur = 0;
  int plan[$];
  int instr_cycles = 0;

  int obs_st[24], obs_alu[24], obs_ext[24], obs_pcen[24], obs_pcsrc[24];
  int obs_ill[24], obs_rw[24], obs_mtr[24], obs_mw[24], obs_iord[24], obs_srcb[24];

  function automatic bit fn_ok(logic [5:0] f);
    return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a;
  endfunction

  function automatic logic [2:0] fn_alu(logic [5:0] f);
    if (f == 6'h22) return 3'b110;
    if (f == 6'h24) return 3'b000;
    if (f == 6'h25) return 3'b001;
    if (f == 6'h2a) return 3'b111;
    return 3'b010;
  endfunction

  // Steps that follow DECODE for each instruction class.
  function automatic void decode_plan(logic [5:0] op);
    plan.delete();
    case (op)
      6'h23:               plan = '{2, 3, 4};
      6'h2b:               plan = '{2, 5};
      6'h00:               plan = '{6, 7};
      6'h04:               plan = '{8};
      6'h08, 6'h0c, 6'h0d: plan = '{9, 10};
      6'h02:               plan = '{11};
      default:             plan.delete();
    endcase
  endfunction

  // Control profile per step, packed as
  // {IorD,IRWrite,MemWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,PCEn,ALUSrcB,PCSrc,ALUControl,ExtOp,illegal_op}
  function automatic logic [16:0] expect_ctrl(int s, logic [5:0] op, logic [5:0] fn,
                                               logic z, logic mr, logic rn);
    logic iord, irw, mw, rw, rd, mtr, srca, pcw, br, ext, ill, pcen;
    logic [1:0] srcb, pcs;
    logic [2:0] alu;
    iord = 0; irw = 0; mw = 0; rw = 0; rd = 0; mtr = 0; srca = 0; pcw = 0; br = 0;
    ext = 1; ill = 0; srcb = 0; pcs = 0; alu = 0;
    case (s)
      0: begin srcb = 2'b01; alu = 3'b010; irw = mr; pcw = mr; end
      1: begin
        srcb = 2'b11; alu = 3'b010;
        ill = !(op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h08 ||
                op == 6'h0c || op == 6'h0d || op == 6'h02 || op == 6'h00) ||
              (op == 6'h00 && !fn_ok(fn));
      end
      2: begin srca = 1; srcb = 2'b10; alu = 3'b010; end
      3: iord = 1;
      4: begin mtr = 1; rw = 1; end
      5: begin iord = 1; mw = 1; end
      6: begin srca = 1; alu = fn_alu(fn); end
      7: begin rd = 1; rw = 1; end
      8: begin srca = 1; alu = 3'b110; pcs = 2'b01; br = 1; end
      9, 10: begin
        if (s == 9) begin srca = 1; srcb = 2'b10; end
        else rw = 1;
        alu = (op == 6'h0c) ? 3'b000 : (op == 6'h0d) ? 3'b001 : 3'b010;
        ext = (op == 6'h08);
      end
      11: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    pcen = pcw | (br & z);
    if (!rn) begin irw = 0; pcen = 0; rw = 0; mw = 0; ill = 0; end
    return {iord, irw, mw, rw, rd, mtr, srca, pcen, srcb, pcs, alu, ext, ill};
  endfunction

  task automatic compare();
    logic [16:0] act, exp;
    act = {bus.IorD, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg,
           bus.ALUSrcA, bus.PCEn, bus.ALUSrcB, bus.PCSrc, bus.ALUControl, bus.ExtOp,
           bus.illegal_op};
    exp = expect_ctrl(model_cur, bus.Op, bus.Funct, bus.Zero, bus.mem_ready, rst_n);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL ctrl step=%0d op=%h act=%05h exp=%05h", model_cur, bus.Op, act, exp);
    end
    checks++;
    if (bus.state !== 4'(model_cur)) begin
      errors++;
      $display("FAIL state act=%0d exp=%0d", bus.state, model_cur);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs seen at it.
  task automatic model_step();
    int prev;
    prev = model_cur;
    instr_cycles++;
    if (!rst_n) begin
      model_cur = 0; plan.delete(); instr_cycles = 0;
      return;
    end
    case (model_cur)
      0: if (bus.mem_ready) model_cur = 1;
      3, 5: if (bus.mem_ready) model_cur = (plan.size() > 0) ? plan.pop_front() : 0;
      default: begin
        if (model_cur == 1) decode_plan(bus.Op);
        model_cur = (plan.size() > 0) ? plan.pop_front() : 0;
      end
    endcase
    if (prev != 0 && model_cur == 0) begin
      $display("txn op=%h funct=%h cycles=%0d", bus.Op, bus.Funct, instr_cycles);
      instr_cycles = 0;
    end
  endtask

  task automatic settle();
    #3;
    compare();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_cur = 0; plan.delete(); instr_cycles = 0;
    #1;
    compare();
  endtask

  // Run one instruction from FETCH back to FETCH, recording each cycle.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic [31:0] mrpat, output int n);
    bus.Op = op; bus.Funct = fn; bus.Zero = z;
    n = 0;
    do begin
      bus.mem_ready = mrpat[n];
      settle();
      obs_st[n] = int'(bus.state); obs_alu[n] = int'(bus.ALUControl);
      obs_ext[n] = int'(bus.ExtOp); obs_pcen[n] = int'(bus.PCEn);
      obs_pcsrc[n] = int'(bus.PCSrc); obs_ill[n] = int'(bus.illegal_op);
      obs_rw[n] = int'(bus.RegWrite); obs_mtr[n] = int'(bus.MemtoReg);
      obs_mw[n] = int'(bus.MemWrite); obs_iord[n] = int'(bus.IorD);
      obs_srcb[n] = int'(bus.ALUSrcB);
      advance();
      n++;
    end while (model_cur != 0 && n < 24);
    if (model_cur != 0) begin
      errors++;
      $display("FAIL timeout op=%h act=state%0d exp=state0", op, model_cur);
    end
  endtask

  initial begin
    int n, cnt;
    logic [5:0] op_tab[8];
    logic [5:0] fn_tab[5];
    logic [2:0] alu_tab[5];
    op_tab = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h0c, 6'h0d, 6'h02};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    alu_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    bus.Op = 6'h00; bus.Funct = 6'h20; bus.Zero = 1'b0; bus.mem_ready = 1'b1;

    // Power-on reset: enables held low even with mem_ready high.
    #1 do_reset();
    chk("rst_state", int'(bus.state), 0);
    chk("rst_irwrite", int'(bus.IRWrite), 0);
    advance();
    rst_n = 1'b1;

    // sw stalled in MEMWR, then reset in the middle of the wait.
    bus.Op = 6'h2b; bus.Funct = 6'h00;
    for (int i = 0; i < 3; i++) begin bus.mem_ready = 1'b1; settle(); advance(); end
    bus.mem_ready = 1'b0;
    settle();
    chk("memwr_wait_mw", int'(bus.MemWrite), 1);
    do_reset();
    chk("rst_memwr_state", int'(bus.state), 0);
    chk("rst_memwr_mw", int'(bus.MemWrite), 0);
    advance();
    rst_n = 1'b1;
    run(6'h2b, 6'h00, 1'b0, 32'hffffffff, n);
    chk("post_rst_srcb", obs_srcb[0], 1);
    chk("post_rst_alu", obs_alu[0], 2);
    chk("sw_cycles", n, 4);

    // lw with memory always ready.
    run(6'h23, 6'h00, 1'b0, 32'hffffffff, n);
    chk("lw_cycles", n, 5);
    for (int i = 0; i < 5; i++) begin
      chk("lw_state", obs_st[i], i);
      chk("lw_regwrite", obs_rw[i], (i == 4) ? 1 : 0);
      chk("lw_memtoreg", obs_mtr[i], (i == 4) ? 1 : 0);
    end

    // sw with two wait cycles in MEMWR.
    run(6'h2b, 6'h00, 1'b0, 32'h00000027, n);
    cnt = 0;
    for (int i = 0; i < n; i++) if (obs_mw[i] == 1 && obs_iord[i] == 1) cnt++;
    chk("sw_wait_cycles", n, 6);
    chk("sw_memwrite_len", cnt, 3);

    // beq taken and not taken.
    run(6'h04, 6'h00, 1'b1, 32'hffffffff, n);
    chk("beq_t_cycles", n, 3);
    chk("beq_t_pcen", obs_pcen[2], 1);
    chk("beq_t_pcsrc", obs_pcsrc[2], 1);
    run(6'h04, 6'h00, 1'b0, 32'hffffffff, n);
    chk("beq_nt_cycles", n, 3);
    chk("beq_nt_pcen", obs_pcen[2], 0);

    // ori zero-extends (imm 0x8000 must not sign-extend); addi sign-extends.
    run(6'h0d, 6'h00, 1'b0, 32'hffffffff, n);
    chk("ori_cycles", n, 4);
    chk("ori_ext_ex", obs_ext[2], 0);
    chk("ori_ext_wb", obs_ext[3], 0);
    chk("ori_alu_ex", obs_alu[2], 1);
    chk("ori_alu_wb", obs_alu[3], 1);
    run(6'h08, 6'h00, 1'b0, 32'hffffffff, n);
    chk("addi_ext", obs_ext[2], 1);
    chk("addi_alu", obs_alu[2], 2);

    // Every R-type function.
    for (int k = 0; k < 5; k++) begin
      run(6'h00, fn_tab[k], 1'b0, 32'hffffffff, n);
      chk("rtype_alu", obs_alu[2], int'(alu_tab[k]));
      chk("rtype_cycles", n, 4);
      chk("rtype_legal", obs_ill[1], 0);
    end

    // Illegal opcode, illegal funct, and jump.
    run(6'h3f, 6'h00, 1'b0, 32'hffffffff, n);
    chk("illop_flag", obs_ill[1], 1);
    chk("illop_cycles", n, 2);
    run(6'h00, 6'h00, 1'b0, 32'hffffffff, n);
    chk("illfn_flag", obs_ill[1], 1);
    chk("illfn_alu", obs_alu[2], 2);
    chk("illfn_cycles", n, 4);
    run(6'h02, 6'h00, 1'b0, 32'hffffffff, n);
    chk("j_cycles", n, 3);
    chk("j_pcsrc", obs_pcsrc[2], 2);
    chk("j_pcen", obs_pcen[2], 1);

    // Randomized run: garbage IR during FETCH, random stalls, Zero and resets.
    for (int c = 0; c < 4000; c++) begin
      if (model_cur == 0) begin
        bus.Op = 6'($urandom); bus.Funct = 6'($urandom);
      end
      bus.Zero = 1'($urandom);
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      settle();
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        advance();
        rst_n = 1'b1;
      end else begin
        advance();
        if (model_cur == 1) begin
          bus.Op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 7)];
          bus.Funct = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Moore-style main controller for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and writeback over several cycles, and drives every datapath mux select and write enable. It also drives the sign/zero-extend mode applied to Instr[15:0] and the shared-memory handshake. It sits beside the datapath and takes its instruction fields from the instruction register.

## Interface
- No parameters; opcode, funct and ALU encodings are fixed below.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- Op  in  6  IR[31:26]; stable from DECODE onward
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  unified memory completes the current access this cycle
- IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA  out  1 each  datapath controls
- PCEn  out  1  PC write enable = PCWrite | (Branch & Zero)
- ALUSrcB  out  2  00 RegB, 01 const 4, 10 ExtImm, 11 ExtImm<<2
- PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- ExtOp  out  1  1 = sign-extend Instr[15:0], 0 = zero-extend
- illegal_op  out  1  one-cycle flag: unsupported opcode/funct seen in DECODE
- state  out  4  current state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11. Codes 12-15 go to FETCH on the next edge.
- Each output is 0 unless listed for the current state. Exception: ExtOp defaults to 1.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, IRWrite=PCWrite=mem_ready. Goes to DECODE when mem_ready=1; otherwise stays.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut). Next state by Op:
  - 100011 lw / 101011 sw -> MEMADR
  - 000000 R-type -> EXECUTE
  - 000100 beq -> BRANCH
  - 001000 addi / 001100 andi / 001101 ori -> IEXEC
  - 000010 j -> JUMP
  - any other Op -> FETCH (executes as a nop), illegal_op=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1; goes to MEMWB when mem_ready=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; goes to FETCH.
- MEMWR: IorD=1, MemWrite=1, both held until mem_ready=1; then goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUControl by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Any other Funct gives 010, and illegal_op=1 in DECODE for that instruction. Goes to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1; goes to FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. ALUControl is 010 for addi, 000 for andi, 001 for ori. ExtOp is 1 for addi and 0 for andi/ori. Goes to IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1, with ExtOp/ALUControl held as in IEXEC; goes to FETCH.
- JUMP: PCSrc=10, PCWrite=1; goes to FETCH.

## Timing
- Only the state register is sequential. It updates on the rising edge of clk.
- All outputs are combinational from state, plus Op/Funct/Zero/mem_ready where stated. PCEn is the only output that depends on Zero.
- Reset (rst_n=0) takes effect asynchronously:
  - state=FETCH immediately.
  - IRWrite, PCEn, RegWrite, MemWrite and illegal_op are forced to 0 while rst_n=0.
  - Mux selects take their FETCH values.
- Reset during any state, including a MEMWR wait, aborts the instruction. No write enable may glitch high.
- First FETCH after reset release: fetch completes on the first edge at which mem_ready=1.
- Latency with mem_ready held at 1: lw 5 cycles, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3, illegal 2.
- Each cycle that mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. No enable is asserted early.
- Op/Funct are sampled only after FETCH, so IR changes in FETCH never affect that cycle.

## Test plan
- Reset mid-MEMWR with mem_ready=0 -> state=0 and MemWrite=0 asynchronously. After release, FETCH outputs are ALUSrcB=01, ALUControl=010.
- lw (Op=100011) with mem_ready=1 -> states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in cycle 5.
- sw with mem_ready low for 2 cycles in MEMWR -> MemWrite=1, IorD=1 for 3 cycles, then FETCH.
- beq with Zero=1 -> PCEn=1 and PCSrc=01 in BRANCH. With Zero=0 -> PCEn=0. Both return to FETCH after 3 cycles.
- ori with Instr imm 16'h8000 -> ExtOp=0 and ALUControl=001 in IEXEC and IWB. addi gives ExtOp=1, ALUControl=010.
- Each R-type funct gives the listed ALUControl. Op=111111 -> illegal_op pulses in DECODE, then FETCH. Funct=000000 -> ALUControl=010 with illegal_op=1.
